req_encoder_16to4: RTL and testbench
====================================

// Module: req_encoder_16to4
// PURPOSE
// - Sequential 16:4 priority encoder that turns sticky one-hot request events into a stream of
//   4-bit binary codes under a valid/ready handshake. It is the reverse of the 4:16 decoder.
// - Sits between event sources (e.g. interrupt lines) and a consumer that needs a binary index.
// - Requests latch into a pending register. The highest-priority unmasked pending bit is
//   presented, held stable, and cleared once accepted.
// PARAMETERS
// - N          16  number of request lines; power of 2, range 2..64
// - W          4   code width; equals $clog2(N)
// - LSB_FIRST  1   1: bit 0 has highest priority; 0: bit N-1 has highest priority
// PORTS
// - clk          in   1  single clock, rising edge
// - rst          in   1  synchronous, active-high reset
// - req_in       in   N  request events; a 1 on any bit in any cycle sets that pending bit
// - mask_in      in   N  1 = line masked; it stays pending but is not eligible for selection
// - code_out     out  W  index of the presented request
// - valid_out    out  1  code_out is valid
// - ready_in     in   1  consumer accepts; handshake = valid_out & ready_in at the rising edge
// - pending_out  out  N  registered copy of the pending register
// - lost_out     out  1  one-cycle pulse: a request hit a bit that was already pending
// BEHAVIOUR
// - Reset: pending=0, code_out=0, valid_out=0, lost_out=0, state=IDLE. A reset in the middle
//   of a handshake discards the presented code and all pending bits.
// - Pending update: pending_nxt = (pending & ~clr) | req_in.
//   - clr is the one-hot of code_out, applied only in the handshake cycle.
//   - If set and clear hit the same bit in the same cycle, set wins; the bit is re-reported.
// - lost_out is registered and asserts the cycle after any bit where
//   req_in & pending & ~clr != 0.
// - Selection: eligible = pending & ~mask_in & ~clr. Only the highest-priority eligible bit is
//   encoded.
// - FSM with two states:
//   - IDLE: if eligible != 0, load code_out, set valid_out, go to PRESENT. Otherwise stay.
//   - PRESENT: hold code_out and valid_out stable while ready_in=0.
//     - Mask changes and new requests never alter or retract a presented code.
//   - On handshake in PRESENT: if eligible != 0, reload code_out, keep valid_out=1, stay in
//     PRESENT (back-to-back, one code per cycle). Otherwise drop valid_out and go to IDLE.
// - Latency: req_in high at edge t makes pending visible after t; valid_out/code_out appear
//   after edge t+1 when in IDLE.
// - Once PRESENT is reached with ready_in=1 every cycle, sustained throughput is one code per
//   clock.
// - Masked bits remain pending indefinitely and are reported once unmasked.
// - All-zero pending never produces valid_out. No combinational path from ready_in to
//   valid_out or code_out.
// STRUCTURE
// - Shared package enc_pkg holds:
//   - typedef enum {IDLE, PRESENT} enc_state_t
//   - function clog2_w
//   - localparam defaults N=16, W=4
// - Sub-module prio_enc_comb (params N, LSB_FIRST): purely combinational. Inputs: N-bit
//   vector. Outputs: W-bit idx and found. Instantiated once on the eligible vector.
// - Top level holds the pending register, the clr one-hot, the FSM, output registers and
//   lost_out detection.
// TESTING
// 1. Reset: assert rst for 2 cycles with req_in=16'hFFFF. Required after reset: valid_out=0,
//    code_out=0, pending_out=0, lost_out=0.
// 2. Single request: req_in=16'h0020 for 1 cycle, ready_in=1. Required: code_out=5 and
//    valid_out=1 for exactly one cycle, 2 edges after the request; then pending_out=0.
// 3. Priority: req_in=16'h8001 for 1 cycle, LSB_FIRST=1, ready_in=1. Required: code 0 then
//    code 15 on consecutive cycles with valid_out held high. With LSB_FIRST=0 the order is
//    15 then 0.
// 4. Backpressure: code 3 presented with ready_in=0 for 5 cycles; req_in=16'h0002 arrives
//    meanwhile. Required: code_out stays 3 for all 5 cycles; after ready_in=1, code 1 follows.
// 5. Mask and lost pulse:
//    - mask_in=16'h00FF, req_in=16'h0101: only code 8 is reported; bit 0 stays pending.
//      Clearing the mask then yields code 0.
//    - A repeated req on bit 2 while it is pending: lost_out=1 for one cycle.
// 6. Round trip with the 4:16 decoder: for all 16 single-bit requests, feed code_out into
//    decoder_4to16. Required: decoder output == request vector. Also, rst asserted while
//    valid_out=1 clears valid_out on the next edge.

Source files
------------

// File: rtl/req_encoder_16to4_pkg.sv
// req_encoder_16to4_pkg: shared types, defaults and width helper for the request encoder
package req_encoder_16to4_pkg;
    localparam int N_DEF = 16;
    localparam int W_DEF = 4;
    typedef enum logic {IDLE, PRESENT} enc_state_t;
    function automatic int clog2_w(input int n);
        int w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) w++;
        return w;
    endfunction
endpackage

// File: rtl/req_encoder_16to4_if.sv
// req_encoder_16to4_if: request/mask inputs and code handshake bundle of the encoder
interface req_encoder_16to4_if
    import req_encoder_16to4_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);
    logic [N-1:0] req_in;
    logic [N-1:0] mask_in;
    logic [W-1:0] code_out;
    logic         valid_out;
    logic         ready_in;
    logic [N-1:0] pending_out;
    logic         lost_out;
    modport master (output req_in, mask_in, ready_in, input code_out, valid_out, pending_out, lost_out);
    modport slave (input req_in, mask_in, ready_in, output code_out, valid_out, pending_out, lost_out);
endinterface

// File: rtl/req_encoder_16to4_prio_enc_comb.sv
// prio_enc_comb: combinational priority encoder returning the index of the winning set bit
module prio_enc_comb
    import req_encoder_16to4_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int LSB_FIRST = 1,
    parameter int W = clog2_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);
    // scan from lowest to highest priority so the last hit wins
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[(LSB_FIRST != 0) ? N - 1 - i : i]) begin
                idx = W'((LSB_FIRST != 0) ? N - 1 - i : i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/req_encoder_16to4.sv
// req_encoder_16to4: sticky request latch feeding a priority-encoded valid/ready code stream
module req_encoder_16to4
    import req_encoder_16to4_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int LSB_FIRST = 1,
    parameter int W = clog2_w(N)
) (
    input logic clk,
    input logic rst,
    req_encoder_16to4_if.slave bus
);
    enc_state_t state, state_nxt;
    logic [N-1:0] pending, clr, eligible;
    logic [W-1:0] code, code_nxt, idx;
    logic valid, valid_nxt, lost, found, hs;
    assign hs = valid & bus.ready_in;
    assign clr = hs ? N'(1) << code : '0;
    assign eligible = pending & ~bus.mask_in & ~clr;
    prio_enc_comb #(.N(N), .LSB_FIRST(LSB_FIRST), .W(W)) u_prio (
        .vec(eligible),
        .idx(idx),
        .found(found)
    );
    // a presented code only changes when idle or on its own handshake
    always_comb begin
        state_nxt = state;
        code_nxt = code;
        valid_nxt = valid;
        if (state == IDLE || hs) begin
            state_nxt = found ? PRESENT : IDLE;
            valid_nxt = found;
            code_nxt = found ? idx : code;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= '0;
            code <= '0;
            valid <= 1'b0;
            lost <= 1'b0;
        end else begin
            state <= state_nxt;
            pending <= (pending & ~clr) | bus.req_in;
            code <= code_nxt;
            valid <= valid_nxt;
            lost <= |(bus.req_in & pending & ~clr);
        end
    end
    assign bus.code_out = code;
    assign bus.valid_out = valid;
    assign bus.pending_out = pending;
    assign bus.lost_out = lost;
endmodule

// File: tb/tb_req_encoder_16to4.sv
// tb_req_encoder_16to4: vector table plus corner sequences, handshakes scored against a queue
module tb_req_encoder_16to4;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];
    logic [15:0] dec;
    typedef struct {
        logic [15:0] req;
        logic [15:0] mask;
        logic [15:0] pend;
        int n;
        logic [3:0][3:0] codes;
    } vec_t;
    vec_t tbl[6];
    req_encoder_16to4_if #(.N(16), .W(4)) if1 ();
    req_encoder_16to4_if #(.N(16), .W(4)) if0 ();
    req_encoder_16to4 #(.N(16), .LSB_FIRST(1), .W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    req_encoder_16to4 #(.N(16), .LSB_FIRST(0), .W(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    assign if0.req_in = if1.req_in;
    assign if0.mask_in = if1.mask_in;
    assign if0.ready_in = if1.ready_in;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        if1.req_in = '0;
        cyc();
        rst = 1'b0;
    endtask

    // the scoreboard sees a handshake half a cycle before the edge that completes it
    always @(negedge clk) begin
        if (!rst && if1.valid_out && if1.ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_code: got %0d expected none", if1.code_out);
            end else chk("sb_code", 32'(if1.code_out), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h0020, 16'h0000, 16'h0000, 1, {4'd0, 4'd0, 4'd0, 4'd5}};
        tbl[1] = '{16'h8001, 16'h0000, 16'h0000, 2, {4'd0, 4'd0, 4'd15, 4'd0}};
        tbl[2] = '{16'h0101, 16'h00FF, 16'h0001, 1, {4'd0, 4'd0, 4'd0, 4'd8}};
        tbl[3] = '{16'h00F0, 16'h0000, 16'h0000, 4, {4'd7, 4'd6, 4'd5, 4'd4}};
        tbl[4] = '{16'hA000, 16'h2000, 16'h2000, 1, {4'd0, 4'd0, 4'd0, 4'd15}};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 0, {4'd0, 4'd0, 4'd0, 4'd0}};
        rst = 1'b1;
        if1.req_in = 16'hFFFF;
        if1.mask_in = '0;
        if1.ready_in = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(if1.valid_out), 0);
        chk("rst_code", 32'(if1.code_out), 0);
        chk("rst_pending", 32'(if1.pending_out), 0);
        chk("rst_lost", 32'(if1.lost_out), 0);
        rst = 1'b0;
        if1.req_in = '0;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            if1.mask_in = tbl[v].mask;
            if1.ready_in = 1'b1;
            if1.req_in = tbl[v].req;
            for (int k = 0; k < tbl[v].n; k++) sb.push_back(tbl[v].codes[k]);
            cyc();
            if1.req_in = '0;
            for (int t = 0; t < 10 && sb.size() > 0; t++) cyc();
            chk($sformatf("vec%0d_drain", v), 32'(sb.size()), 0);
            cyc();
            chk($sformatf("vec%0d_pending", v), 32'(if1.pending_out), 32'(tbl[v].pend));
            chk($sformatf("vec%0d_idle", v), 32'(if1.valid_out), 0);
        end
        if1.mask_in = '0;
        // single request timing: valid for exactly one cycle, two edges after the request
        do_reset();
        if1.ready_in = 1'b1;
        if1.req_in = 16'h0020;
        cyc();
        chk("single_t0_valid", 32'(if1.valid_out), 0);
        chk("single_t0_pending", 32'(if1.pending_out), 32'h0020);
        if1.req_in = '0;
        sb.push_back(4'd5);
        cyc();
        chk("single_valid", 32'(if1.valid_out), 1);
        chk("single_code", 32'(if1.code_out), 5);
        cyc();
        chk("single_drop", 32'(if1.valid_out), 0);
        chk("single_pending", 32'(if1.pending_out), 0);
        // priority order for both LSB_FIRST settings
        do_reset();
        if1.ready_in = 1'b1;
        if1.req_in = 16'h8001;
        sb.push_back(4'd0);
        sb.push_back(4'd15);
        cyc();
        if1.req_in = '0;
        cyc();
        chk("prio_lsb_first", 32'({if1.valid_out, if1.code_out}), 32'h10);
        chk("prio_msb_first", 32'({if0.valid_out, if0.code_out}), 32'h1F);
        cyc();
        chk("prio_lsb_second", 32'({if1.valid_out, if1.code_out}), 32'h1F);
        chk("prio_msb_second", 32'({if0.valid_out, if0.code_out}), 32'h10);
        cyc();
        chk("prio_done", 32'({if1.valid_out, if0.valid_out}), 0);
        // backpressure holds the presented code while new requests arrive
        do_reset();
        if1.ready_in = 1'b0;
        if1.req_in = 16'h0008;
        sb.push_back(4'd3);
        sb.push_back(4'd1);
        cyc();
        if1.req_in = '0;
        cyc();
        chk("bp_first", 32'({if1.valid_out, if1.code_out}), 32'h13);
        if1.req_in = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if1.req_in = '0;
            chk($sformatf("bp_hold%0d", i), 32'({if1.valid_out, if1.code_out}), 32'h13);
        end
        if1.ready_in = 1'b1;
        cyc();
        chk("bp_next", 32'({if1.valid_out, if1.code_out}), 32'h11);
        cyc();
        chk("bp_done", 32'(if1.valid_out), 0);
        // masked bit stays pending until unmasked
        do_reset();
        if1.mask_in = 16'h00FF;
        if1.ready_in = 1'b1;
        if1.req_in = 16'h0101;
        sb.push_back(4'd8);
        cyc();
        if1.req_in = '0;
        cyc();
        chk("mask_code8", 32'({if1.valid_out, if1.code_out}), 32'h18);
        cyc();
        chk("mask_held_valid", 32'(if1.valid_out), 0);
        chk("mask_held_pending", 32'(if1.pending_out), 32'h0001);
        if1.mask_in = '0;
        sb.push_back(4'd0);
        cyc();
        chk("unmask_code0", 32'({if1.valid_out, if1.code_out}), 32'h10);
        cyc();
        chk("unmask_pending", 32'(if1.pending_out), 0);
        // lost pulse on a repeated request, none when set and clear collide
        do_reset();
        if1.ready_in = 1'b0;
        if1.req_in = 16'h0004;
        sb.push_back(4'd2);
        cyc();
        chk("lost_none", 32'(if1.lost_out), 0);
        cyc();
        chk("lost_pulse", 32'(if1.lost_out), 1);
        chk("lost_code", 32'({if1.valid_out, if1.code_out}), 32'h12);
        if1.req_in = '0;
        cyc();
        chk("lost_clear", 32'(if1.lost_out), 0);
        if1.ready_in = 1'b1;
        if1.req_in = 16'h0004;
        sb.push_back(4'd2);
        cyc();
        if1.req_in = '0;
        chk("setwin_lost", 32'(if1.lost_out), 0);
        chk("setwin_valid", 32'(if1.valid_out), 0);
        chk("setwin_pending", 32'(if1.pending_out), 32'h0004);
        cyc();
        chk("setwin_rereport", 32'({if1.valid_out, if1.code_out}), 32'h12);
        cyc();
        chk("setwin_pending_end", 32'(if1.pending_out), 0);
        // round trip through a 4:16 decode
        do_reset();
        if1.ready_in = 1'b1;
        for (int b = 0; b < 16; b++) begin
            if1.req_in = 16'h0001 << b;
            sb.push_back(4'(b));
            cyc();
            if1.req_in = '0;
            cyc();
            dec = 16'h0001 << if1.code_out;
            chk($sformatf("rt%0d", b), 32'({if1.valid_out, dec}), 32'h10000 | (32'h1 << b));
            cyc();
        end
        // reset in the middle of a presented code
        if1.ready_in = 1'b0;
        if1.req_in = 16'h0010;
        cyc();
        if1.req_in = '0;
        cyc();
        chk("midrst_before", 32'(if1.valid_out), 1);
        rst = 1'b1;
        sb.delete();
        cyc();
        chk("midrst_valid", 32'(if1.valid_out), 0);
        chk("midrst_pending", 32'(if1.pending_out), 0);
        rst = 1'b0;
        cyc();
        chk("midrst_stays", 32'(if1.valid_out), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
